// File: rtl/typing_pkg.sv
// Shared types for the typing game score block: FSM states, score type, saturating helpers.
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [7:0] score_t;

  localparam score_t SCORE_MAX = 8'hFF;

  function automatic score_t score_inc(score_t s);
    return (s == SCORE_MAX) ? s : s + 8'd1;
  endfunction

  function automatic score_t score_dec(score_t s);
    return (s == 8'd0) ? s : s - 8'd1;
  endfunction

endpackage

// File: rtl/typing_score_tick_gen.sv
// One-second prescaler: pulses tick once every TICKS_PER_SEC enabled cycles, held at zero while disabled.
module tick_gen
  import typing_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/typing_score.sv
// Typing game scorer: counts correct keystrokes during a timed round.
// Optional feature macro TYPING_PENALTY_EN: mismatched keys in a round subtract one point.
module typing_score
  import typing_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ROUND_SECONDS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic [7:0] target_code,
  output logic [7:0] res,
  output logic [7:0] time_left,
  output logic       clr,
  output logic       hit,
  output logic       done
);

  localparam logic [7:0] ROUND_INIT = 8'(ROUND_SECONDS);

  state_t     state;
  state_t     state_n;
  score_t     res_n;
  logic [7:0] time_left_n;
  logic       clr_n;
  logic       hit_n;
  logic       done_n;
  logic       start_q;
  logic       start_armed;
  logic       start_edge;
  logic       run_en;
  logic       tick;

  assign run_en = (state == RUN);

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .tick(tick)
  );

  // start must be seen low after reset before a rising edge counts, so a level held through reset is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) begin
        start_armed <= 1'b1;
      end
    end
  end

  assign start_edge = start && !start_q && start_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    res_n       = res;
    time_left_n = time_left;
    hit_n       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          state_n     = RUN;
          res_n       = 8'd0;
          time_left_n = ROUND_INIT;
        end
      end
      RUN: begin
        if (key_valid) begin
          if (key_code == target_code) begin
            res_n = score_inc(res);
            hit_n = 1'b1;
          end
`ifdef TYPING_PENALTY_EN
          else begin
            res_n = score_dec(res);
          end
`endif
        end
        // a key landing on the final tick is still scored before the round closes
        if (tick) begin
          time_left_n = time_left - 8'd1;
          if (time_left == 8'd1) begin
            state_n = DONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    clr_n  = (state_n == IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= 8'd0;
      time_left <= 8'd0;
      clr       <= 1'b1;
      hit       <= 1'b0;
      done      <= 1'b0;
    end else begin
      res       <= res_n;
      time_left <= time_left_n;
      clr       <= clr_n;
      hit       <= hit_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_typing_score.sv
// Self-checking bench for typing_score: a round-level model checked every cycle plus directed literal checks.
module tb_typing_score;

  localparam int TP_S = 4;
  localparam int RS_S = 3;
  localparam int TP_B = 1000;
  localparam int RS_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s;
  logic       start_b;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] target_code;

  logic [7:0] res_s, time_left_s, res_b, time_left_b;
  logic       clr_s, hit_s, done_s, clr_b, hit_b, done_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  typing_score #(.TICKS_PER_SEC(TP_S), .ROUND_SECONDS(RS_S)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .key_valid(key_valid),
    .key_code(key_code), .target_code(target_code),
    .res(res_s), .time_left(time_left_s), .clr(clr_s), .hit(hit_s), .done(done_s)
  );

  typing_score #(.TICKS_PER_SEC(TP_B), .ROUND_SECONDS(RS_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key_valid(key_valid),
    .key_code(key_code), .target_code(target_code),
    .res(res_b), .time_left(time_left_b), .clr(clr_b), .hit(hit_b), .done(done_b)
  );

  // phase: 0 = waiting for first round, 1 = round running, 2 = round over
  typedef struct {
    int phase;
    int score;
    int elapsed;
    int tleft;
    bit hit;
    bit prev_start;
    bit seen_low;
  } mdl_t;

  mdl_t ms;
  mdl_t mb;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.phase = 0; n.score = 0; n.elapsed = 0; n.tleft = 0;
    n.hit = 1'b0; n.prev_start = 1'b0; n.seen_low = 1'b0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit st, bit kv, logic [7:0] kc,
                                    logic [7:0] tc, int tp, int rs);
    mdl_t n = m;
    bit   new_round;
    new_round = st && !m.prev_start && m.seen_low;
    n.hit = 1'b0;
    if (m.phase == 1) begin
      if (kv) begin
        if (kc == tc) begin
          n.hit = 1'b1;
          if (n.score < 255) n.score = n.score + 1;
        end
`ifdef TYPING_PENALTY_EN
        else if (n.score > 0) begin
          n.score = n.score - 1;
        end
`endif
      end
      n.elapsed = m.elapsed + 1;
      n.tleft   = rs - n.elapsed / tp;
      if (n.elapsed == tp * rs) n.phase = 2;
    end else if (new_round) begin
      n.phase = 1; n.score = 0; n.elapsed = 0; n.tleft = rs;
    end
    n.prev_start = st;
    if (!st) n.seen_low = 1'b1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms = mdl_reset();
      mb = mdl_reset();
    end else begin
      ms = mdl_step(ms, start_s, key_valid, key_code, target_code, TP_S, RS_S);
      mb = mdl_step(mb, start_b, key_valid, key_code, target_code, TP_B, RS_B);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared = compared + 1;
    if (actual != expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model res_s",  int'(res_s),       ms.score);
    checkOutput("model tl_s",   int'(time_left_s), ms.tleft);
    checkOutput("model clr_s",  int'(clr_s),       int'(ms.phase == 0));
    checkOutput("model hit_s",  int'(hit_s),       int'(ms.hit));
    checkOutput("model done_s", int'(done_s),      int'(ms.phase == 2));
    checkOutput("model res_b",  int'(res_b),       mb.score);
    checkOutput("model tl_b",   int'(time_left_b), mb.tleft);
    checkOutput("model clr_b",  int'(clr_b),       int'(mb.phase == 0));
    checkOutput("model hit_b",  int'(hit_b),       int'(mb.hit));
    checkOutput("model done_b", int'(done_b),      int'(mb.phase == 2));
  end

  task automatic applyStimulus(input logic st_s, input logic st_b, input logic kv,
                               input logic [7:0] kc, input logic [7:0] tc);
    @(negedge clk);
    start_s     = st_s;
    start_b     = st_b;
    key_valid   = kv;
    key_code    = kc;
    target_code = tc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h41, 8'h41);
  endtask

  task automatic startSmall();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h41, 8'h41);
  endtask

  initial begin
    rst = 1'b1; start_s = 1'b0; start_b = 1'b0;
    key_valid = 1'b0; key_code = 8'h00; target_code = 8'h00;

    @(negedge clk);
    checkOutput("reset clr",  int'(clr_s), 1);
    checkOutput("reset res",  int'(res_s), 0);
    checkOutput("reset tl",   int'(time_left_s), 0);
    checkOutput("reset done", int'(done_s), 0);
    rst = 1'b0;
    idle(2);

    $display("[TB] round start and timeout");
    startSmall();
    idle(1);
    checkOutput("start clr", int'(clr_s), 0);
    checkOutput("start tl",  int'(time_left_s), 3);
    checkOutput("start res", int'(res_s), 0);
    idle(11);
    checkOutput("pre-end done", int'(done_s), 0);
    checkOutput("pre-end tl",   int'(time_left_s), 1);
    idle(1);
    checkOutput("end done", int'(done_s), 1);
    checkOutput("end tl",   int'(time_left_s), 0);

    $display("[TB] five correct keys");
    startSmall();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
      checkOutput("key hit low", int'(hit_s), 0);
      idle(1);
      checkOutput("key hit", int'(hit_s), 1);
      checkOutput("key res", int'(res_s), i + 1);
    end
    idle(6);
    checkOutput("five done", int'(done_s), 1);
    checkOutput("five res",  int'(res_s), 5);

    $display("[TB] key on final tick");
    startSmall();
    idle(11);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
    idle(1);
    checkOutput("final res",  int'(res_s), 1);
    checkOutput("final done", int'(done_s), 1);
    checkOutput("final hit",  int'(hit_s), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
    idle(1);
    checkOutput("after done res", int'(res_s), 1);
    checkOutput("after done hit", int'(hit_s), 0);

    $display("[TB] mismatched key");
    startSmall();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
      idle(1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h42, 8'h41);
    idle(1);
`ifdef TYPING_PENALTY_EN
    checkOutput("mismatch res", int'(res_s), 2);
`else
    checkOutput("mismatch res", int'(res_s), 3);
`endif
    checkOutput("mismatch hit", int'(hit_s), 0);
    idle(8);
    startSmall();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h42, 8'h41);
    idle(1);
    checkOutput("mismatch at zero", int'(res_s), 0);
    idle(12);

    $display("[TB] reset mid-round");
    startSmall();
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h41, 8'h41);
    checkOutput("pre-reset res", int'(res_s), 7);
    #2 rst = 1'b1;
    #1;
    checkOutput("async res",  int'(res_s), 0);
    checkOutput("async clr",  int'(clr_s), 1);
    checkOutput("async done", int'(done_s), 0);
    checkOutput("async tl",   int'(time_left_s), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h41, 8'h41);
    checkOutput("held start clr", int'(clr_s), 1);
    checkOutput("held start tl",  int'(time_left_s), 0);
    idle(2);

    $display("[TB] score saturation");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h41, 8'h41);
    for (int i = 0; i < 254; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
    checkOutput("preload res", int'(res_b), 254);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 8'h41);
    checkOutput("sat res 1", int'(res_b), 255);
    checkOutput("sat hit 1", int'(hit_b), 1);
    idle(1);
    checkOutput("sat res 2", int'(res_b), 255);
    checkOutput("sat hit 2", int'(hit_b), 1);
    checkOutput("idle key res", int'(res_s), 0);
    checkOutput("idle key hit", int'(hit_s), 0);
    idle(1);
    checkOutput("sat hit off", int'(hit_b), 0);
    idle(2800);
    checkOutput("big done", int'(done_b), 1);
    checkOutput("big res",  int'(res_b), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
